onchip_memory_arbiter: RTL and testbench

Two-master arbiter that shares the single-port 32-bit on-chip memory (10000 words, 14-bit word address) between the two NIOS processors.
- Presents two Avalon-MM pipelined slave ports upstream and drives the memory's address, byteenable, chipselect, write, writedata and clken inputs downstream.
- Round-robin grant, one command per cycle, fixed one-cycle read latency.
- Optional bus lock for atomic read-modify-write on shared image buffers.

---
 rtl/onchip_arb_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 38 +++
 rtl/onchip_memory_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_onchip_memory_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_arb_pkg.sv
// Shared types and default sizes for the two-master on-chip memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package onchip_arb_pkg;

  localparam int ARB_ADDR_W       = 14;
  localparam int ARB_DATA_W       = 32;
  localparam int ARB_NUM_WORDS    = 10000;
  localparam int ARB_LOCK_TIMEOUT = 256;

  // Index of an upstream master (0 or 1)
  typedef logic master_idx_t;

  // Bus lock ownership
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } lock_state_t;

  // Which masters may be granted in a given lock state (bit n = master n)
  function automatic logic [1:0] lock_allow(input lock_state_t st);
    logic [1:0] m;
    m = 2'b11;
    case (st)
      LOCK0:   m = 2'b01;
      LOCK1:   m = 2'b10;
      default: m = 2'b11;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin grant; a tie goes to the master not granted last.
// Latency: grant is combinational from the requests in the same cycle.
// Backpressure: losing requester is simply not granted; it must hold its request.
module rr_arbiter2
  import onchip_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  master_idx_t r_last_grant;
  logic [1:0]  w_grant;

  // Lone requester wins; with both requesting, favour the one not granted last
  always_comb begin
    w_grant = 2'b00;
    case (i_req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
      default: w_grant = 2'b00;
    endcase
  end

  // Remember the most recent winner; idle cycles leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (|w_grant) begin
      r_last_grant <= w_grant[1];
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/onchip_memory_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-MM pipelined masters (optional bus lock: ONCHIP_ARB_LOCK_EN).
// Latency: commands accepted in the grant cycle; read data returns exactly 1 cycle after acceptance.
// Backpressure: mN_waitrequest holds off the losing/locked-out master; no read-data backpressure.
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDR_W,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int NUM_WORDS = ARB_NUM_WORDS
`ifdef ONCHIP_ARB_LOCK_EN
  ,
  parameter int LOCK_TIMEOUT = ARB_LOCK_TIMEOUT
`endif
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic                  m0_lock,
  input  logic                  m1_lock,
`endif
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int              BE_W     = DATA_W / 8;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(NUM_WORDS);

  logic [1:0]        w_req;
  logic [1:0]        w_allow;
  logic [1:0]        w_arb_req;
  logic [1:0]        w_grant;
  logic              w_any_grant;
  master_idx_t       w_sel;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [BE_W-1:0]   w_sel_be;
  logic [DATA_W-1:0] w_sel_wdat;
  logic              w_sel_wr;
  logic              w_sel_rd;
  logic              w_in_range;
  logic              w_rd_acc;
  logic [DATA_W-1:0] w_rdata;

  logic              r_rd_pend;
  master_idx_t       r_rd_owner;
  logic              r_rd_oor;

  // A master requests with either strobe; write wins when both are set
  assign w_req = {m1_read | m1_write, m0_read | m0_write};

`ifdef ONCHIP_ARB_LOCK_EN
  localparam int               CNT_W        = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LP_IDLE_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  lock_state_t      r_lock_state;
  lock_state_t      w_lock_next;
  logic [CNT_W-1:0] r_idle_cnt;
  logic [CNT_W-1:0] w_idle_cnt_next;
  logic             w_owner_req;
  logic             w_owner_grant;
  logic             w_owner_lock;

  assign w_allow = lock_allow(r_lock_state);

  // Lock state and owner-idle counter; reset drops any held lock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_state <= IDLE;
      r_idle_cnt   <= '0;
    end else begin
      r_lock_state <= w_lock_next;
      r_idle_cnt   <= w_idle_cnt_next;
    end
  end

  // Enter a lock on a granted locked transfer; leave on an unlocked transfer or owner idle timeout
  always_comb begin
    w_lock_next     = r_lock_state;
    w_idle_cnt_next = '0;
    w_owner_req     = 1'b0;
    w_owner_grant   = 1'b0;
    w_owner_lock    = 1'b0;
    case (r_lock_state)
      IDLE: begin
        if (w_grant[0] && m0_lock) begin
          w_lock_next = LOCK0;
        end else if (w_grant[1] && m1_lock) begin
          w_lock_next = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if (r_lock_state == LOCK0) begin
          w_owner_req   = w_req[0];
          w_owner_grant = w_grant[0];
          w_owner_lock  = m0_lock;
        end else begin
          w_owner_req   = w_req[1];
          w_owner_grant = w_grant[1];
          w_owner_lock  = m1_lock;
        end
        if (w_owner_grant && !w_owner_lock) begin
          w_lock_next = IDLE;
        end else if (w_owner_req) begin
          w_idle_cnt_next = '0;
        end else if (r_idle_cnt == LP_IDLE_LAST) begin
          w_lock_next = IDLE;
        end else begin
          w_idle_cnt_next = r_idle_cnt + CNT_W'(1);
        end
      end
      default: w_lock_next = IDLE;
    endcase
  end
`else
  assign w_allow = 2'b11;
`endif

  // Nothing is granted while reset is asserted
  assign w_arb_req = w_req & w_allow & {2{~reset}};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst     (reset),
    .i_req   (w_arb_req),
    .o_grant (w_grant)
  );

  assign w_any_grant = |w_grant;
  assign w_sel       = w_grant[1];

  // Command mux: the granted master drives the memory port
  always_comb begin
    w_sel_addr = m0_address;
    w_sel_be   = m0_byteenable;
    w_sel_wdat = m0_writedata;
    w_sel_wr   = m0_write;
    w_sel_rd   = m0_read;
    if (w_sel) begin
      w_sel_addr = m1_address;
      w_sel_be   = m1_byteenable;
      w_sel_wdat = m1_writedata;
      w_sel_wr   = m1_write;
      w_sel_rd   = m1_read;
    end
  end

  // Out-of-range commands are still accepted but never reach the memory
  assign w_in_range = ({1'b0, w_sel_addr} < LP_DEPTH);
  assign w_rd_acc   = w_any_grant & w_sel_rd & ~w_sel_wr;

  assign mem_address    = w_sel_addr;
  assign mem_byteenable = w_sel_be;
  assign mem_writedata  = w_sel_wdat;
  assign mem_write      = w_any_grant & w_sel_wr;
  assign mem_chipselect = w_any_grant & w_in_range;
  assign mem_clken      = 1'b1;

  assign m0_waitrequest = reset | (w_req[0] & ~w_grant[0]);
  assign m1_waitrequest = reset | (w_req[1] & ~w_grant[1]);

  // Track the one outstanding read so its data is steered back next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_rd_oor   <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_owner <= w_sel;
        r_rd_oor   <= ~w_in_range;
      end
    end
  end

  // Both masters see the same data; each qualifies it with its own valid
  assign w_rdata          = r_rd_oor ? '0 : mem_readdata;
  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = r_rd_pend & (r_rd_owner == 1'b0);
  assign m1_readdatavalid = r_rd_pend & (r_rd_owner == 1'b1);

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter with a behavioural memory and reference model.
// Latency: expects readdatavalid exactly one cycle after a read is accepted.
// Backpressure: masters hold their command while waitrequest is high.
module tb_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_lock = 1'b0, m1_lock = 1'b0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [13:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  onchip_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
`ifdef ONCHIP_ARB_LOCK_EN
    .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Single-port memory with one-cycle registered read
  logic [31:0] emu_mem [0:9999];
  initial for (int i = 0; i < 10000; i++) emu_mem[i] <= '0;
  always @(posedge clk) begin
    if (mem_chipselect && mem_address < 14'd10000) begin
      if (mem_write) emu_mem[mem_address] <= merge(emu_mem[mem_address], mem_writedata, mem_byteenable);
      else           mem_readdata <= emu_mem[mem_address];
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [13:0] a0, input logic [3:0] be0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [13:0] a1,
                       input logic [3:0] be1, input logic [31:0] d1,
                       input logic l0 = 1'b0, input logic l1 = 1'b0);
    @(negedge clk);
    m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0; m0_lock = l0;
    m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1; m1_lock = l1;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b1, 1'b0, 14'd6, 4'hF, 32'h0);
    checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait0 got=%b exp=1", m0_waitrequest); end
    checks++; if (m1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_wait1 got=%b exp=1", m1_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs got=%b exp=0", mem_chipselect); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", mem_write); end
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL reset_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
    checks++; if (mem_clken !== 1'b1) begin errors++; $display("FAIL clken got=%b exp=1", mem_clken); end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_contention();
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b1, 1'b0, 14'd6, 4'hF, 32'h0);
      else idle();
      if (k < 4) begin
        checks++; if (m0_waitrequest !== (k % 2 == 1)) begin errors++; $display("FAIL cont_wait0 k=%0d got=%b", k, m0_waitrequest); end
        checks++; if (m1_waitrequest !== (k % 2 == 0)) begin errors++; $display("FAIL cont_wait1 k=%0d got=%b", k, m1_waitrequest); end
      end
      checks++; if (m0_readdatavalid !== (k > 0 && (k - 1) % 2 == 0)) begin errors++; $display("FAIL cont_rdv0 k=%0d got=%b", k, m0_readdatavalid); end
      checks++; if (m1_readdatavalid !== (k > 0 && (k - 1) % 2 == 1)) begin errors++; $display("FAIL cont_rdv1 k=%0d got=%b", k, m1_readdatavalid); end
    end
  endtask

  task automatic test_single_master();
    drive(1'b0, 1'b1, 14'd5, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_wr_wait got=%b exp=0", m0_waitrequest); end
    checks++; if ({mem_chipselect, mem_write} !== 2'b11) begin errors++; $display("FAIL single_wr_strobes got=%b exp=11", {mem_chipselect, mem_write}); end
    checks++; if (mem_address !== 14'd5) begin errors++; $display("FAIL single_wr_addr got=%0d exp=5", mem_address); end
    drive(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL single_rd_wait got=%b exp=0", m0_waitrequest); end
    checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_wr_norv got=%b exp=0", m0_readdatavalid); end
    idle();
    checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL single_rdv got=%b exp=1", m0_readdatavalid); end
    checks++; if (m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got=%h exp=deadbeef", m0_readdata); end
    checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL single_rdv1 got=%b exp=0", m1_readdatavalid); end
  endtask

  task automatic test_byte_enables();
    drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 1'b1, 14'd7, 4'hF, 32'h11223344);
    drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b0, 1'b1, 14'd7, 4'h3, 32'hAABBCCDD);
    drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 1'b0, 14'd7, 4'hF, 32'h0);
    idle();
    checks++; if (m1_readdatavalid !== 1'b1) begin errors++; $display("FAIL be_rdv got=%b exp=1", m1_readdatavalid); end
    checks++; if (m1_readdata !== 32'h1122CCDD) begin errors++; $display("FAIL be_rdata got=%h exp=1122ccdd", m1_readdata); end
  endtask

  task automatic test_out_of_range();
    drive(1'b0, 1'b1, 14'd10000, 4'hF, 32'h12345678, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL oor_wr_wait got=%b exp=0", m0_waitrequest); end
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL oor_wr_cs got=%b exp=0", mem_chipselect); end
    drive(1'b1, 1'b0, 14'd10000, 4'hF, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (mem_chipselect !== 1'b0) begin errors++; $display("FAIL oor_rd_cs got=%b exp=0", mem_chipselect); end
    idle();
    checks++; if (m0_readdatavalid !== 1'b1) begin errors++; $display("FAIL oor_rdv got=%b exp=1", m0_readdatavalid); end
    checks++; if (m0_readdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=0", m0_readdata); end
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rstrd_acc got=%b exp=0", m0_waitrequest); end
    @(negedge clk);
    m0_read = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) begin errors++; $display("FAIL rstrd_rdv got=%b exp=00", {m0_readdatavalid, m1_readdatavalid}); end
    idle();
    reset = 1'b0;
    drive(1'b1, 1'b0, 14'd5, 4'hF, 32'h0, 1'b1, 1'b0, 14'd6, 4'hF, 32'h0);
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b01) begin errors++; $display("FAIL rstrd_first got=%b exp=01", {m0_waitrequest, m1_waitrequest}); end
    idle();
    checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rstrd_after got=%b/%h exp=1/deadbeef", m0_readdatavalid, m0_readdata); end
  endtask

  task automatic test_random();
    logic [31:0] mm [0:31];
    logic        cr [0:1], cw [0:1], busy [0:1], req [0:1];
    logic [13:0] ca [0:1];
    logic [3:0]  cb [0:1];
    logic [31:0] cd [0:1];
    logic [31:0] exp_d;
    logic        exp_v;
    int          fav, win, exp_own;
    for (int i = 0; i < 32; i++) mm[i] = '0;
    for (int n = 0; n < 2; n++) begin busy[n] = 1'b0; cr[n] = 1'b0; cw[n] = 1'b0; ca[n] = '0; cb[n] = '0; cd[n] = '0; end
    pulse_reset();
    fav = 0; exp_v = 1'b0; exp_own = 0; exp_d = '0;
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!busy[n]) begin
          int k;
          k = $urandom_range(0, 9);
          cr[n] = (k >= 3 && k <= 5) || k == 9;
          cw[n] = (k >= 6);
          ca[n] = ($urandom_range(0, 7) == 0) ? 14'(10000 + $urandom_range(0, 6383)) : 14'(100 + $urandom_range(0, 31));
          cb[n] = 4'($urandom_range(0, 15));
          cd[n] = $urandom;
        end
      end
      drive(cr[0], cw[0], ca[0], cb[0], cd[0], cr[1], cw[1], ca[1], cb[1], cd[1]);
      req[0] = cr[0] | cw[0];
      req[1] = cr[1] | cw[1];
      if (req[0] && req[1]) win = fav;
      else if (req[0]) win = 0;
      else if (req[1]) win = 1;
      else win = -1;
      checks++; if (m0_waitrequest !== (req[0] && win != 0)) begin errors++; $display("FAIL rnd_wait0 c=%0d got=%b", c, m0_waitrequest); end
      checks++; if (m1_waitrequest !== (req[1] && win != 1)) begin errors++; $display("FAIL rnd_wait1 c=%0d got=%b", c, m1_waitrequest); end
      checks++; if (mem_chipselect !== (win >= 0 && ca[win < 0 ? 0 : win] < 14'd10000)) begin errors++; $display("FAIL rnd_cs c=%0d got=%b", c, mem_chipselect); end
      checks++; if (m0_readdatavalid !== (exp_v && exp_own == 0)) begin errors++; $display("FAIL rnd_rdv0 c=%0d got=%b", c, m0_readdatavalid); end
      checks++; if (m1_readdatavalid !== (exp_v && exp_own == 1)) begin errors++; $display("FAIL rnd_rdv1 c=%0d got=%b", c, m1_readdatavalid); end
      if (exp_v) begin
        checks++;
        if ((exp_own == 0 ? m0_readdata : m1_readdata) !== exp_d) begin
          errors++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, (exp_own == 0 ? m0_readdata : m1_readdata), exp_d);
        end
      end
      exp_v = 1'b0;
      if (win >= 0) begin
        if (cw[win]) begin
          if (ca[win] < 14'd10000) mm[ca[win] - 14'd100] = merge(mm[ca[win] - 14'd100], cd[win], cb[win]);
        end else begin
          exp_v = 1'b1;
          exp_own = win;
          exp_d = (ca[win] < 14'd10000) ? mm[ca[win] - 14'd100] : 32'h0;
        end
        fav = 1 - win;
      end
      busy[0] = req[0] && win != 0;
      busy[1] = req[1] && win != 1;
    end
    idle();
    checks++; if ({m1_readdatavalid, m0_readdatavalid} !== {exp_v && exp_own == 1, exp_v && exp_own == 0}) begin errors++; $display("FAIL rnd_tail got=%b", {m1_readdatavalid, m0_readdatavalid}); end
  endtask

`ifdef ONCHIP_ARB_LOCK_EN
  task automatic test_lock();
    int held;
    pulse_reset();
    drive(1'b0, 1'b0, 14'd0, 4'h0, 32'h0, 1'b1, 1'b0, 14'd100, 4'hF, 32'h0, 1'b0, 1'b1);
    checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL lock_take got=%b exp=0", m1_waitrequest); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 14'd101, 4'hF, 32'h0, 1'b1, 1'b0, 14'd100, 4'hF, 32'h0, 1'b0, (k < 3));
      checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin errors++; $display("FAIL lock_hold k=%0d got=%b exp=10", k, {m0_waitrequest, m1_waitrequest}); end
    end
    drive(1'b1, 1'b0, 14'd101, 4'hF, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
    checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL lock_release got=%b exp=0", m0_waitrequest); end
    drive(1'b1, 1'b0, 14'd101, 4'hF, 32'h0, 1'b1, 1'b0, 14'd100, 4'hF, 32'h0, 1'b0, 1'b1);
    checks++; if ({m0_waitrequest, m1_waitrequest} !== 2'b10) begin errors++; $display("FAIL lock_retake got=%b exp=10", {m0_waitrequest, m1_waitrequest}); end
    held = 0;
    for (int k = 0; k < 400; k++) begin
      drive(1'b1, 1'b0, 14'd101, 4'hF, 32'h0, 1'b0, 1'b0, 14'd0, 4'h0, 32'h0);
      if (m0_waitrequest !== 1'b1) break;
      held++;
    end
    checks++; if (held != 256) begin errors++; $display("FAIL lock_timeout got=%0d exp=256", held); end
    idle();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_single_master();
    test_byte_enables();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
`ifdef ONCHIP_ARB_LOCK_EN
    test_lock();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
